// File: rtl/mem_arbiter_if.sv
// Purpose: groups the IF fetch port, DM data port, memory port and stall counter of mem_arbiter.
// Latency: none (wires only).
// Backpressure: req held until ready/ack; slave = arbiter side, master = pipeline/memory side.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // Fetch stage port
    logic          if_req_i;
    logic [AW-1:0] if_addr_i;
    logic          flush_i;
    logic          if_ready_o;
    logic [DW-1:0] if_rdata_o;
    // Data stage port
    logic          dm_req_i;
    logic          dm_we_i;
    logic [AW-1:0] dm_addr_i;
    logic [DW-1:0] dm_wdata_i;
    logic          dm_ready_o;
    logic [DW-1:0] dm_rdata_o;
    // Memory port
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_ack_i;
    logic [DW-1:0] mem_rdata_i;
    // Memory-induced stall cycle counter
    logic [15:0]   stall_cnt_o;

    modport slave (
        input  if_req_i, if_addr_i, flush_i,
        input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        input  mem_ack_i, mem_rdata_i,
        output if_ready_o, if_rdata_o, dm_ready_o, dm_rdata_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output stall_cnt_o
    );

    modport master (
        output if_req_i, if_addr_i, flush_i,
        output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        output mem_ack_i, mem_rdata_i,
        input  if_ready_o, if_rdata_o, dm_ready_o, dm_rdata_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  stall_cnt_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Purpose: arbitrates IF/DM stages onto one single-port memory (DM priority), counts stall cycles.
// Latency: req cycle 0 -> mem_req_o cycle 1 -> ack cycle k -> ready pulse k+1 -> idle k+2.
// Backpressure: requesters hold req until their ready pulse; memory holds off via mem_ack_i.
// Ports: clk_i, rst_i (async active-low) plus bus (mem_arbiter_if.slave) carrying all handshakes.
module mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY, RESP} state_t;

    state_t        state_q, state_d;
    logic          owner_dm_q, owner_dm_d;
    logic          drop_q, drop_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic [15:0]   stall_q, stall_d;

    logic busy;
    logic if_ready;
    logic dm_ready;

    // All outputs are decoded from state or come straight from registers.
    assign busy     = (state_q == IF_BUSY) || (state_q == DM_BUSY);
    assign if_ready = (state_q == RESP) && !owner_dm_q && !drop_q;
    assign dm_ready = (state_q == RESP) && owner_dm_q;

    assign bus.mem_req_o   = busy;
    assign bus.mem_we_o    = busy && we_q;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_wdata_o = wdata_q;
    assign bus.if_ready_o  = if_ready;
    assign bus.dm_ready_o  = dm_ready;
    assign bus.if_rdata_o  = if_rdata_q;
    assign bus.dm_rdata_o  = dm_rdata_q;
    assign bus.stall_cnt_o = stall_q;

    always_comb begin
        state_d    = state_q;
        owner_dm_d = owner_dm_q;
        drop_d     = drop_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;

        case (state_q)
            IDLE: begin
                // Data access wins: it belongs to the older instruction.
                if (bus.dm_req_i) begin
                    state_d    = DM_BUSY;
                    owner_dm_d = 1'b1;
                    addr_d     = bus.dm_addr_i;
                    we_d       = bus.dm_we_i;
                    wdata_d    = bus.dm_wdata_i;
                end else if (bus.if_req_i) begin
                    state_d    = IF_BUSY;
                    owner_dm_d = 1'b0;
                    addr_d     = bus.if_addr_i;
                    we_d       = 1'b0;
                    wdata_d    = '0;
                end
            end
            IF_BUSY, DM_BUSY: begin
                // A flushed fetch still runs to completion on the memory side;
                // only its ready pulse is swallowed.
                if ((state_q == IF_BUSY) && bus.flush_i) begin
                    drop_d = 1'b1;
                end
                if (bus.mem_ack_i) begin
                    state_d = RESP;
                    if (owner_dm_q) begin
                        dm_rdata_d = bus.mem_rdata_i;
                    end else begin
                        if_rdata_d = bus.mem_rdata_i;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
                drop_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Saturating count of cycles where a stage waits on memory.
    always_comb begin
        stall_d = stall_q;
        if ((bus.if_req_i || bus.dm_req_i) && !if_ready && !dm_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            owner_dm_q <= 1'b0;
            drop_q     <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_dm_q <= owner_dm_d;
            drop_q     <= drop_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            stall_q    <= stall_d;
        end
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter and sequencer for a single-port unified instruction/data memory shared by the IF and MEM stages of the 5-stage pipeline. Grants one stage's request at a time, holds the memory handshake, and returns registered read data with a one-cycle ready pulse. A stage stalls while its request is pending. Also counts memory-induced stall cycles. Sits between the pipeline stage registers and the memory model, alongside the load-use hazard unit.

## Interface
- AW, 32, address width
- DW, 32, data width
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- if_req_i  in  1  fetch request, held until if_ready_o
- if_addr_i  in  AW  fetch address
- flush_i  in  1  branch/jump flush from pipeline control
- if_ready_o  out  1  fetch complete pulse
- if_rdata_o  out  DW  fetched instruction
- dm_req_i  in  1  data request, held until dm_ready_o
- dm_we_i  in  1  1 = store, 0 = load
- dm_addr_i  in  AW  data address
- dm_wdata_i  in  DW  store data
- dm_ready_o  out  1  data access complete pulse
- dm_rdata_o  out  DW  load data
- mem_req_o  out  1  memory request, held until mem_ack_i
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  AW  memory address
- mem_wdata_o  out  DW  memory write data
- mem_ack_i  in  1  single-cycle completion; mem_rdata_i valid same cycle
- mem_rdata_i  in  DW  memory read data
- stall_cnt_o  out  16  saturating count of cycles with any request pending and no ready

## Operation
- FSM states: IDLE, IF_BUSY, DM_BUSY, RESP.
- IDLE: dm_req_i → DM_BUSY (data priority, older instruction); else if_req_i → IF_BUSY; else stay. On grant, latch owner, address, we (0 for IF), wdata.
- IF_BUSY/DM_BUSY: mem_req_o=1, mem_addr_o/mem_we_o/mem_wdata_o from latched values, stable until ack. On mem_ack_i: capture mem_rdata_i into owner's rdata register (stores capture too; value don't-care), → RESP.
- RESP: pulse owner's ready for exactly one cycle; requests ignored; → IDLE.
- Flush: flush_i in IF_BUSY sets drop flag; transaction completes, if_rdata_o updated, if_ready_o suppressed in RESP. Drop flag cleared on entering IDLE. flush_i in IDLE, DM_BUSY, RESP: no effect on FSM.
- if_ready_o = RESP && owner==IF && !drop; dm_ready_o = RESP && owner==DM.
- Latched request fields ignore input changes after grant.
- stall_cnt_o increments when (if_req_i || dm_req_i) && !if_ready_o && !dm_ready_o; saturates at 16'hFFFF.
- Store and load identical except mem_we_o.

## Timing
- Reset (rst_i=0, async): state IDLE, drop=0, all outputs 0 including rdata registers and stall_cnt_o. Reset mid-transaction abandons it; mem_req_o drops immediately.
- All outputs registered or decoded from state; no combinational path from request inputs to outputs.
- Latency: req seen cycle 0 → mem_req_o high cycle 1 → ack cycle k≥1 → ready pulse cycle k+1 → IDLE cycle k+2; minimum 2 cycles req-to-ready, 3 cycles per access.
- Both requests in same IDLE cycle: DM granted; IF granted at next IDLE if still held.
- mem_ack_i outside IF_BUSY/DM_BUSY ignored.
- No timeout; a missing ack stalls indefinitely.

## Test plan
- IF only, addr 0x40, ack 1 cycle after mem_req_o, rdata 0x00500093 → mem_addr_o=0x40, if_ready_o pulse cycle 2, if_rdata_o=0x00500093, stall_cnt_o=2.
- Simultaneous IF 0x44 and DM load 0x100 (mem returns 0xDEADBEEF) → DM served first with dm_rdata_o=0xDEADBEEF, then IF; mem_addr_o sequence 0x100, 0x44; no overlap.
- DM store 0x200 data 0x12345678, ack delayed 4 cycles → mem_we_o=1, mem_wdata_o stable 4 cycles, dm_ready_o single pulse; dm_addr_i changed mid-wait does not alter mem_addr_o.
- flush_i during IF_BUSY for 0x48, new if_addr_i 0x80 → 0x48 access completes, no if_ready_o; next grant to 0x80 returns its data with pulse.
- rst_i low while DM_BUSY → mem_req_o, readies, stall_cnt_o 0 immediately; after release, fresh IF request served normally.
- Requests held 70000 cycles with no ack → stall_cnt_o saturates at 0xFFFF.
